// File: rtl/pulse_cnt_bank.sv
// pulse_cnt_bank: gates, edge-counts and saturates pulse channels under a run/clear FSM,
// and streams a header plus a snapshot of every counter as bytes over a req/ack handshake.
module pulse_cnt_bank #(
    parameter int          P_N_CH  = 8,
    parameter int          P_CNT_W = 32,
    parameter logic [7:0]  P_HDR   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              clr,
    input  logic [P_N_CH-1:0] pulse_in,
    output logic [P_N_CH-1:0] pulse_gated,
    output logic              running,
    output logic              all_sat,
    input  logic              dump_req,
    output logic              dump_busy,
    output logic              byte_req,
    output logic [7:0]        byte_data,
    input  logic              byte_ack
);
    localparam int NB = 1 + P_N_CH * (P_CNT_W / 8);
    localparam int SW = 8 * NB;
    localparam int IW = $clog2(NB);

    typedef enum logic {S_IDLE, S_RUN} run_t;
    typedef enum logic {D_IDLE, D_SEND} dump_t;

    run_t                             state, state_nxt;
    dump_t                            d_state, d_nxt;
    logic [P_N_CH-1:0][P_CNT_W-1:0]   cnt, cnt_nxt;
    logic [P_N_CH-1:0]                pulse_prev, rise, gate_nxt, sat;
    logic [P_N_CH*P_CNT_W-1:0]        snap_word;
    logic [SW-1:0]                    sh, sh_nxt;
    logic [IW-1:0]                    idx, idx_nxt;
    logic                             accept, ack, last;

    assign rise      = pulse_in & ~pulse_prev;
    assign running   = state == S_RUN;
    assign dump_busy = d_state == D_SEND;
    assign byte_req  = dump_busy;
    assign byte_data = byte_req ? sh[SW-1 -: 8] : 8'h00;

    always_comb begin
        state_nxt = clr ? S_IDLE : (state == S_IDLE && run) ? S_RUN : state;
        gate_nxt  = '0;
        sat       = '0;
        cnt_nxt   = cnt;
        snap_word = '0;
        for (int i = 0; i < P_N_CH; i++) begin
            gate_nxt[i] = rise[i] & running & (cnt[i] != '1);
            sat[i]      = cnt[i] == '1;
            cnt_nxt[i]  = clr ? '0 : cnt[i] + P_CNT_W'(gate_nxt[i]);
            // channel 0 lands in the most significant slot so it leaves the shifter first
            snap_word[(P_N_CH-1-i)*P_CNT_W +: P_CNT_W] = cnt[i];
        end
    end

    always_comb begin
        accept  = d_state == D_IDLE && dump_req;
        ack     = d_state == D_SEND && byte_ack;
        last    = idx == IW'(NB - 1);
        d_nxt   = accept ? D_SEND : (ack && last) ? D_IDLE : d_state;
        sh_nxt  = accept ? {P_HDR, snap_word} : ack ? sh << 8 : sh;
        idx_nxt = accept ? '0 : ack ? idx + IW'(1) : idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            d_state     <= D_IDLE;
            cnt         <= '0;
            pulse_prev  <= '0;
            pulse_gated <= '0;
            all_sat     <= 1'b0;
            sh          <= '0;
            idx         <= '0;
        end else begin
            state       <= state_nxt;
            d_state     <= d_nxt;
            cnt         <= cnt_nxt;
            pulse_prev  <= pulse_in;
            pulse_gated <= gate_nxt;
            all_sat     <= ~clr & (&sat);
            sh          <= sh_nxt;
            idx         <= idx_nxt;
        end
    end
endmodule

// File: tb/tb_pulse_cnt_bank.sv
// tb_pulse_cnt_bank: directed checks of counting, gating, saturation, clear and byte dumps.
module tb_pulse_cnt_bank;
    logic        clk = 0, rst_n = 0, run = 0, clr = 0, dump_req = 0, byte_ack = 0;
    logic [7:0]  pulse_in = '0;
    logic [7:0]  pulse_gated, byte_data;
    logic        running, all_sat, dump_busy, byte_req;
    logic [7:0][31:0] fv;
    logic [7:0]  got [0:63];
    int          checks = 0, errors = 0, n, gcnt, late;

    pulse_cnt_bank dut (
        .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .pulse_in(pulse_in),
        .pulse_gated(pulse_gated), .running(running), .all_sat(all_sat),
        .dump_req(dump_req), .dump_busy(dump_busy), .byte_req(byte_req),
        .byte_data(byte_data), .byte_ack(byte_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        logic [31:0] w;
        if (k == 0) return 8'hA5;
        w = fv[(k - 1) / 4];
        return w[31 - 8 * ((k - 1) % 4) -: 8];
    endfunction

    task automatic set_cnts();
        force dut.cnt = fv;
        @(posedge clk);
        #1;
        release dut.cnt;
        @(negedge clk);
    endtask

    task automatic pulse(input int ch);
        pulse_in[ch] = 1'b1;
        @(negedge clk);
        gcnt += int'(pulse_gated[ch]);
        pulse_in[ch] = 1'b0;
        @(negedge clk);
        late += int'(pulse_gated[ch]);
    endtask

    task automatic do_dump(input int period, input bit noise, input int abort_at);
        n = 0;
        dump_req = 1;
        @(negedge clk);
        dump_req = 0;
        chk("busy_on", {dump_busy, byte_req}, 2'b11);
        for (int k = 0; k < 400 && byte_req; k++) begin
            byte_ack = (k % period) == period - 1;
            if (noise) begin
                pulse_in = (k % 2 == 1) ? 8'h0C : 8'h00;
                clr      = k == 10;
                dump_req = k == 5;
            end
            if (n == abort_at) begin
                rst_n = 0;
                #1;
                chk("abort_req_busy", {byte_req, dump_busy}, 2'b00);
                chk("abort_cnt_zero", 64'(dut.cnt == '0), 1);
                break;
            end
            if (byte_ack) begin
                got[n] = byte_data;
                n++;
            end
            @(negedge clk);
        end
        byte_ack = 0; pulse_in = '0; clr = 0; dump_req = 0;
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_len"}, 64'(n), 33);
        chk({tag, "_busy_off"}, {dump_busy, byte_req}, 2'b00);
        for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), got[i], exp_byte(i));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outs", {pulse_gated, running, all_sat, dump_busy, byte_req, byte_data}, 0);
        rst_n = 1;
        // 1: five distinct pulses on ch3
        run = 1;
        @(negedge clk);
        chk("t1_running", running, 1);
        gcnt = 0; late = 0;
        repeat (5) pulse(3);
        chk("t1_cnt3", dut.cnt[3], 5);
        chk("t1_gated3", 64'(gcnt), 5);
        chk("t1_no_late", 64'(late), 0);
        // 2: held-high pulse counts once
        gcnt = 0;
        pulse_in[0] = 1;
        repeat (20) begin
            @(negedge clk);
            gcnt += int'(pulse_gated[0]);
        end
        pulse_in[0] = 0;
        @(negedge clk);
        gcnt += int'(pulse_gated[0]);
        chk("t2_cnt0", dut.cnt[0], 1);
        chk("t2_gated0", 64'(gcnt), 1);
        // 3: saturation, all_sat and clear
        fv = '0;
        fv[1] = 32'hFFFF_FFFE;
        set_cnts();
        gcnt = 0; late = 0;
        repeat (3) pulse(1);
        chk("t3_cnt1", dut.cnt[1], 32'hFFFF_FFFF);
        chk("t3_gated1", 64'(gcnt + late), 1);
        chk("t3_not_all_sat", all_sat, 0);
        fv = '1;
        set_cnts();
        chk("t3_all_sat", all_sat, 1);
        gcnt = 0; late = 0;
        pulse(2);
        chk("t3_sat_no_gate", 64'(gcnt + late), 0);
        run = 0; clr = 1;
        @(negedge clk);
        clr = 0;
        chk("t3_clr_sat", all_sat, 0);
        chk("t3_clr_running", running, 0);
        chk("t3_clr_cnt", 64'(dut.cnt == '0), 1);
        // 4: dump with ack every cycle
        for (int i = 0; i < 8; i++) fv[i] = {4{8'(8'h10 + i)}};
        fv[0] = 32'h0102_0304;
        fv[7] = 32'hAABB_CCDD;
        set_cnts();
        do_dump(1, 0, -1);
        chk("t4_first", {got[0], got[1], got[2], got[3], got[4]}, 40'hA5_0102_0304);
        chk("t4_last", {got[29], got[30], got[31], got[32]}, 32'hAABB_CCDD);
        chk_stream("t4");
        // 5: slow ack while counting, clearing and re-requesting
        for (int i = 0; i < 8; i++) fv[i] = 32'h1111_1111 * (i + 1);
        set_cnts();
        run = 1;
        do_dump(3, 1, -1);
        chk_stream("t5");
        byte_ack = 1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_requeue", {dump_busy, byte_req}, 2'b00);
        end
        byte_ack = 0;
        // 6: clr beats run; reset aborts a dump
        run = 1; clr = 1;
        repeat (2) begin
            @(negedge clk);
            chk("t6_clr_prio", running, 0);
        end
        run = 0; clr = 0;
        fv = '1;
        fv[4] = 32'h1234_5678;
        set_cnts();
        do_dump(1, 0, 9);
        chk("t6_bytes_before_abort", 64'(n), 9);
        @(negedge clk);
        chk("t6_rst_outs", {pulse_gated, running, all_sat, dump_busy, byte_req, byte_data}, 0);
        rst_n = 1;
        @(negedge clk);
        chk("t6_idle_after", {dump_busy, running}, 2'b00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
